// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader: widths, frame marker,
// FSM state encoding and the running checksum helper.
package program_loader_pkg;

  localparam int         INSTR_WIDTH_DEF = 28;
  localparam int         ADDR_WIDTH_DEF  = 16;
  localparam int         DEPTH_DEF       = 256;
  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         CNT_W           = 16;
  localparam int         INSTR_W         = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake plus RAM write port and CPU control outputs of the loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
);

  logic [7:0]             iByte;
  logic                   iByteValid;
  logic                   oByteReady;
  logic                   oWriteEnable;
  logic [ADDR_WIDTH-1:0]  oWriteAddress;
  logic [INSTR_WIDTH-1:0] oWriteData;
  logic                   oCpuReset;
  logic                   oDone;
  logic                   oError;

  modport master (
    output iByte, iByteValid,
    input  oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuReset, oDone, oError
  );

  modport slave (
    input  iByte, iByteValid,
    output oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuReset, oDone, oError
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four big-endian bytes into one instruction word; the first byte's
// upper nibble must be zero, so only its low nibble is kept.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_full,
  output logic               nib_err
);

  localparam int SHIFT_W = INSTR_W - 8;

  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clear) begin
      byte_cnt_d = '0;
    end else if (shift_en) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[SHIFT_W-9:0], byte_in};
    end
  end

  // Word and flags include the byte being accepted now, so the caller can act in the same cycle.
  assign word      = {shift_q, byte_in};
  assign word_full = shift_en && (byte_cnt_q == 2'd3);
  assign nib_err   = shift_en && (byte_cnt_q == 2'd0) && (byte_in[7:4] != 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/program_loader.sv
// Frame parser that writes 28-bit words into instruction RAM and releases the
// CPU only after a full frame with a matching XOR checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int         ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int         DEPTH       = DEPTH_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
)(
  input  logic              Clock,
  input  logic              Reset,
  program_loader_if.slave   bus
);

  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   xfer;
  logic [CNT_W-1:0]       n_new;
  logic                   asm_clear;
  logic                   asm_shift;
  logic [INSTR_W-1:0]     asm_word;
  logic                   asm_full;
  logic                   asm_nib_err;

  assign xfer      = bus.iByteValid & ready_q;
  assign n_new     = {cnt_q[7:0], bus.iByte};
  assign asm_shift = xfer && (state_q == S_DATA);
  assign asm_clear = (state_q != S_DATA) && (state_q != S_WRITE);

  program_loader_word_assembler u_asm (
    .clk       (Clock),
    .rst       (Reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (bus.iByte),
    .word      (asm_word),
    .word_full (asm_full),
    .nib_err   (asm_nib_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (xfer && (bus.iByte == SYNC_BYTE)) begin
          state_d = S_CNT_H;
          chk_d   = '0;
        end
      end
      S_CNT_H: begin
        if (xfer) begin
          cnt_d   = {8'h00, bus.iByte};
          chk_d   = chk_update(chk_q, bus.iByte);
          state_d = S_CNT_L;
        end
      end
      S_CNT_L: begin
        if (xfer) begin
          cnt_d = n_new;
          chk_d = chk_update(chk_q, bus.iByte);
          idx_d = '0;
          if (n_new > DEPTH_N) begin
            state_d = S_ERR;
          end else if (n_new == '0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_d = chk_update(chk_q, bus.iByte);
          if (asm_nib_err) begin
            state_d = S_ERR;
          end else if (asm_full) begin
            state_d = S_WRITE;
            waddr_d = ADDR_WIDTH'(idx_q);
            wdata_d = INSTR_WIDTH'(asm_word);
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = ((idx_q + 1'b1) == cnt_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = (bus.iByte == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every output is a registered function of the state being entered.
    ready_d   = (state_d != S_WRITE);
    we_d      = (state_d == S_WRITE);
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.oByteReady    = ready_q;
  assign bus.oWriteEnable  = we_q;
  assign bus.oWriteAddress = waddr_q;
  assign bus.oWriteData    = wdata_q;
  assign bus.oCpuReset     = cpu_rst_q;
  assign bus.oDone         = done_q;
  assign bus.oError        = err_q;

endmodule
